change_dispenser: RTL and testbench

//  Downstream of the credit/purchase controller. Accepts a change amount in cents via valid/ready and pays it
//  out greedily with the quarter, dime and nickel servos. Emits one coin_pulse per coin so the controller can

---
 rtl/vend_pkg.sv | 38 +++
 rtl/change_dispenser_if.sv | 13 +
 rtl/dispense_timer.sv | 29 ++
 rtl/change_dispenser.sv | 216 +++++++++++++++++++++
 tb/tb_change_dispenser.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared constants, FSM encodings and tube codes for the change dispenser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vend_pkg;

    localparam logic [4:0] COIN_NICKEL  = 5'd5;
    localparam logic [4:0] COIN_DIME    = 5'd10;
    localparam logic [4:0] COIN_QUARTER = 5'd25;

    localparam logic [1:0] POS_REST = 2'b00;
    localparam logic [1:0] POS_PUSH = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_PUSH    = 3'd2,
        S_RETRACT = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    // Tube codes double as the restock_sel encoding.
    typedef enum logic [1:0] {
        TUBE_Q    = 2'd0,
        TUBE_D    = 2'd1,
        TUBE_N    = 2'd2,
        TUBE_NONE = 2'd3
    } tube_e;

    function automatic logic [4:0] tube_value(input tube_e t);
        case (t)
            TUBE_Q:  tube_value = COIN_QUARTER;
            TUBE_D:  tube_value = COIN_DIME;
            TUBE_N:  tube_value = COIN_NICKEL;
            default: tube_value = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change request channel: amount in cents with valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: ready is driven by the dispenser, high only while it is idle.
interface change_dispenser_if #(
    parameter int AMT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount;

    modport master (output req_valid, output req_amount, input req_ready);
    modport slave  (input req_valid, input req_amount, output req_ready);
endinterface

// File: rtl/dispense_timer.sv
// Loadable down-counter timing servo push and retract phases.
// Latency: load takes effect next cycle; expired is combinational on count==0.
// Backpressure: none; load always wins over counting.
module dispense_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy quarter/dime/nickel payout of a requested change amount, one coin_pulse per coin.
// Latency: accept -> done strobe in 2 + N*(1+HOLD_CYCLES+GAP_CYCLES) cycles for N coins.
// Backpressure: req_ready high only in IDLE; optional tube inventory under CHANGE_INVENTORY_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 16,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 25_000_000
`ifdef CHANGE_INVENTORY_EN
    ,
    parameter int INV_W       = 8,
    parameter int INIT_STOCK  = 20
`endif
) (
    input  logic             clock,
    input  logic             reset,
    change_dispenser_if.slave req,
    input  logic             abort,
    output logic [1:0]       motor_pos_q,
    output logic [1:0]       motor_pos_d,
    output logic [1:0]       motor_pos_n,
    output logic             coin_pulse,
    output logic [4:0]       coin_value,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] dispensed,
    output logic             residue,
    output logic             shortfall
`ifdef CHANGE_INVENTORY_EN
    ,
    input  logic             restock_valid,
    input  logic [1:0]       restock_sel,
    input  logic [INV_W-1:0] restock_count,
    output logic [INV_W-1:0] stock_q,
    output logic [INV_W-1:0] stock_d,
    output logic [INV_W-1:0] stock_n
`endif
);

    // HOLD_CYCLES and GAP_CYCLES are assumed to be at least 1.
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0]    HOLD_LD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    GAP_LD   = TW'(GAP_CYCLES - 1);
    localparam logic [AMT_W-1:0] AMT_Q    = AMT_W'(COIN_QUARTER);
    localparam logic [AMT_W-1:0] AMT_D    = AMT_W'(COIN_DIME);
    localparam logic [AMT_W-1:0] AMT_N    = AMT_W'(COIN_NICKEL);

    state_e           state;
    state_e           state_nx;
    tube_e            coin;
    tube_e            pick;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] req_mod5;
    logic             abort_seen;
    logic             first_push;
    logic             accept;
    logic             commit;
    logic             tmr_load;
    logic [TW-1:0]    tmr_value;
    logic             tmr_expired;
    logic             has_q;
    logic             has_d;
    logic             has_n;

    assign accept   = req.req_valid && (state == S_IDLE);
    assign req_mod5 = req.req_amount % AMT_N;
    // A coin is committed on the SELECT -> PUSH transition.
    assign commit   = (state == S_SELECT) && (state_nx == S_PUSH);

`ifdef CHANGE_INVENTORY_EN
    logic [INV_W-1:0] stock [3];
    logic [INV_W:0]   stock_sum [3];
    logic             shortfall_r;

    assign has_q = (remaining >= AMT_Q) && (stock[0] != '0);
    assign has_d = (remaining >= AMT_D) && (stock[1] != '0);
    assign has_n = (remaining >= AMT_N) && (stock[2] != '0);

    // Net per-tube change: restock and dispense in the same cycle both apply.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stock_sum[i] = {1'b0, stock[i]}
                + ((restock_valid && (restock_sel == 2'(i))) ? {1'b0, restock_count} : '0)
                - ((commit && (2'(pick) == 2'(i))) ? {{INV_W{1'b0}}, 1'b1} : '0);
        end
    end

    // Tube stock registers, saturating at all-ones; never underflow since empty tubes are skipped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                stock[i] <= INV_W'(INIT_STOCK);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                stock[i] <= stock_sum[i][INV_W] ? '1 : stock_sum[i][INV_W-1:0];
            end
        end
    end

    // Shortfall is sticky from a dry SELECT until the next accepted request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shortfall_r <= 1'b0;
        end else if (accept) begin
            shortfall_r <= 1'b0;
        end else if ((state == S_SELECT) && (pick == TUBE_NONE) && (remaining != '0)) begin
            shortfall_r <= 1'b1;
        end
    end

    assign shortfall = shortfall_r;
    assign stock_q   = stock[0];
    assign stock_d   = stock[1];
    assign stock_n   = stock[2];
`else
    // Tubes never run dry, so a multiple-of-5 remainder is always payable.
    assign has_q     = (remaining >= AMT_Q);
    assign has_d     = (remaining >= AMT_D);
    assign has_n     = (remaining >= AMT_N);
    assign shortfall = 1'b0;
`endif

    assign pick = has_q ? TUBE_Q : (has_d ? TUBE_D : (has_n ? TUBE_N : TUBE_NONE));

    dispense_timer #(.W(TW)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and timer load decisions.
    always_comb begin
        state_nx  = state;
        tmr_load  = 1'b0;
        tmr_value = HOLD_LD;
        case (state)
            S_IDLE: begin
                if (accept) state_nx = S_SELECT;
            end
            S_SELECT: begin
                if ((pick == TUBE_NONE) || abort) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx  = S_PUSH;
                    tmr_load  = 1'b1;
                    tmr_value = HOLD_LD;
                end
            end
            S_PUSH: begin
                if (tmr_expired) begin
                    state_nx  = S_RETRACT;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LD;
                end
            end
            S_RETRACT: begin
                if (tmr_expired) state_nx = (abort_seen || abort) ? S_DONE : S_SELECT;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Transaction datapath: amount bookkeeping, chosen coin and abort latch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining  <= '0;
            dispensed  <= '0;
            residue    <= 1'b0;
            coin       <= TUBE_Q;
            abort_seen <= 1'b0;
            first_push <= 1'b0;
        end else begin
            first_push <= 1'b0;
            if (accept) begin
                remaining  <= req.req_amount - req_mod5;
                dispensed  <= '0;
                residue    <= (req_mod5 != '0);
                abort_seen <= 1'b0;
            end else if (commit) begin
                coin       <= pick;
                remaining  <= remaining - AMT_W'(tube_value(pick));
                dispensed  <= dispensed + AMT_W'(tube_value(pick));
                first_push <= 1'b1;
                abort_seen <= 1'b0;
            end else if (((state == S_PUSH) || (state == S_RETRACT)) && abort) begin
                abort_seen <= 1'b1;
            end
        end
    end

    assign req.req_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign coin_pulse    = (state == S_PUSH) && first_push;
    assign coin_value    = coin_pulse ? tube_value(coin) : 5'd0;
    // Decoded from the state register so reset forces every servo to rest immediately.
    assign motor_pos_q   = ((state == S_PUSH) && (coin == TUBE_Q)) ? POS_PUSH : POS_REST;
    assign motor_pos_d   = ((state == S_PUSH) && (coin == TUBE_D)) ? POS_PUSH : POS_REST;
    assign motor_pos_n   = ((state == S_PUSH) && (coin == TUBE_N)) ? POS_PUSH : POS_REST;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser with HOLD_CYCLES=4, GAP_CYCLES=2.
// Cycle k is the clock period ending at the k-th rising edge after the accepting edge 0.
// Inventory scenarios run only when CHANGE_INVENTORY_EN is defined.
module tb_change_dispenser;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  motor_pos_q, motor_pos_d, motor_pos_n;
    logic        coin_pulse;
    logic [4:0]  coin_value;
    logic        busy, done, residue, shortfall;
    logic [15:0] dispensed;
`ifdef CHANGE_INVENTORY_EN
    logic        restock_valid = 1'b0;
    logic [1:0]  restock_sel = 2'd0;
    logic [7:0]  restock_count = 8'd0;
    logic [7:0]  stock_q, stock_d, stock_n;
`endif

    change_dispenser_if #(.AMT_W(16)) req_if ();

    change_dispenser #(
        .AMT_W       (16),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2)
`ifdef CHANGE_INVENTORY_EN
        ,
        .INV_W       (8),
        .INIT_STOCK  (0)
`endif
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req_if.slave),
        .abort       (abort),
        .motor_pos_q (motor_pos_q),
        .motor_pos_d (motor_pos_d),
        .motor_pos_n (motor_pos_n),
        .coin_pulse  (coin_pulse),
        .coin_value  (coin_value),
        .busy        (busy),
        .done        (done),
        .dispensed   (dispensed),
        .residue     (residue),
        .shortfall   (shortfall)
`ifdef CHANGE_INVENTORY_EN
        ,
        .restock_valid (restock_valid),
        .restock_sel   (restock_sel),
        .restock_count (restock_count),
        .stock_q       (stock_q),
        .stock_d       (stock_d),
        .stock_n       (stock_n)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int coins[$];
    int done_cyc, mq, md, mn, excl_err, cv_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    function automatic int coin_at(input int i);
        coin_at = (coins.size() > i) ? coins[i] : -1;
    endfunction

    // Handshake one request, then watch outputs each cycle until done (or stop_cyc).
    task automatic run_req(input int amt, input int abort_cyc, input int stop_cyc);
        coins.delete();
        done_cyc = -1; mq = 0; md = 0; mn = 0; excl_err = 0; cv_err = 0;
        @(negedge clock);
        req_if.req_valid  = 1'b1;
        req_if.req_amount = amt[15:0];
        @(posedge clock);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            req_if.req_valid = 1'b0;
            if (coin_pulse) coins.push_back(int'(coin_value));
            else if (coin_value != 5'd0) cv_err++;
            if (motor_pos_q == 2'b01) mq++;
            if (motor_pos_d == 2'b01) md++;
            if (motor_pos_n == 2'b01) mn++;
            if ((int'(motor_pos_q != 2'b00) + int'(motor_pos_d != 2'b00) + int'(motor_pos_n != 2'b00)) > 1) excl_err++;
            if (motor_pos_q[1] || motor_pos_d[1] || motor_pos_n[1]) excl_err++;
            if (done) begin
                done_cyc = k;
                break;
            end
            if (k == stop_cyc) break;
            abort = (k + 1 == abort_cyc) ? 1'b1 : 1'b0;
        end
        abort = 1'b0;
    endtask

`ifdef CHANGE_INVENTORY_EN
    task automatic restock(input logic [1:0] sel, input logic [7:0] cnt);
        @(negedge clock);
        restock_valid = 1'b1; restock_sel = sel; restock_count = cnt;
        @(negedge clock);
        restock_valid = 1'b0;
    endtask
`endif

    initial begin
        req_if.req_valid  = 1'b0;
        req_if.req_amount = 16'd0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_req_ready", req_if.req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_motors", {motor_pos_q, motor_pos_d, motor_pos_n}, 0);
        check("rst_coin_pulse", coin_pulse, 0);
        check("rst_dispensed", dispensed, 0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_req_ready", req_if.req_ready, 1);

        // 40 cents: quarter, dime, nickel
        run_req(40, 0, 0);
        check("r40_ncoins", coins.size(), 3);
        check("r40_coin0", coin_at(0), 25);
        check("r40_coin1", coin_at(1), 10);
        check("r40_coin2", coin_at(2), 5);
        check("r40_hold_q", mq, 4);
        check("r40_hold_d", md, 4);
        check("r40_hold_n", mn, 4);
        check("r40_done_cyc", done_cyc, 23);
        check("r40_dispensed", dispensed, 40);
        check("r40_motor_excl", excl_err, 0);
        check("r40_coin_value_idle", cv_err, 0);
        check("r40_residue", residue, 0);

        // 43 cents: residue flagged, 40 paid
        run_req(43, 0, 0);
        check("r43_residue", residue, 1);
        check("r43_coin0", coin_at(0), 25);
        check("r43_coin1", coin_at(1), 10);
        check("r43_coin2", coin_at(2), 5);
        check("r43_dispensed", dispensed, 40);
        check("r43_shortfall", shortfall, 0);
        check("r43_done_cyc", done_cyc, 23);

        // 0 cents: straight to done, residue cleared
        run_req(0, 0, 0);
        check("r0_ncoins", coins.size(), 0);
        check("r0_motors", mq + md + mn, 0);
        check("r0_done_cyc", done_cyc, 2);
        check("r0_residue", residue, 0);
        check("r0_dispensed", dispensed, 0);

        // 75 cents with abort during the first push
        run_req(75, 3, 0);
        check("ab_ncoins", coins.size(), 1);
        check("ab_coin0", coin_at(0), 25);
        check("ab_hold_q", mq, 4);
        check("ab_done_cyc", done_cyc, 8);
        check("ab_dispensed", dispensed, 25);
        check("ab_motor_q_rest", motor_pos_q, 0);
        @(negedge clock);
        check("ab_idle_busy", busy, 0);

        // Reset asserted mid-push
        run_req(40, 0, 3);
        check("mr_q_pushing", motor_pos_q, 1);
        #2 reset = 1'b0;
        #1;
        check("mr_motors_rest", {motor_pos_q, motor_pos_d, motor_pos_n}, 0);
        check("mr_busy", busy, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mr_req_ready", req_if.req_ready, 1);
        check("mr_dispensed", dispensed, 0);
        run_req(10, 0, 0);
        check("mr10_ncoins", coins.size(), 1);
        check("mr10_coin0", coin_at(0), 10);
        check("mr10_hold_d", md, 4);
        check("mr10_done_cyc", done_cyc, 9);
        check("mr10_dispensed", dispensed, 10);

`ifdef CHANGE_INVENTORY_EN
        // Empty quarter tube: 30 cents paid in dimes
        restock(2'd1, 8'd3);
        check("inv_stock_d3", stock_d, 3);
        check("inv_stock_q0", stock_q, 0);
        run_req(30, 0, 0);
        check("inv30_ncoins", coins.size(), 3);
        check("inv30_coin0", coin_at(0), 10);
        check("inv30_coin1", coin_at(1), 10);
        check("inv30_coin2", coin_at(2), 10);
        check("inv30_shortfall", shortfall, 0);
        check("inv30_stock_d", stock_d, 0);
        // One dime, no nickels: 15 cents falls short
        restock(2'd1, 8'd1);
        check("inv_stock_n0", stock_n, 0);
        run_req(15, 0, 0);
        check("inv15_ncoins", coins.size(), 1);
        check("inv15_coin0", coin_at(0), 10);
        check("inv15_shortfall", shortfall, 1);
        check("inv15_dispensed", dispensed, 10);
        check("inv15_done_cyc", done_cyc, 9);
        // Saturating restock
        restock(2'd0, 8'd200);
        restock(2'd0, 8'd100);
        check("inv_sat_q", stock_q, 255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
